clkdiv_monitor: RTL and testbench
=================================

# clkdiv_monitor

Checks a divided clock produced by the team's clock-divider blocks (e.g. the 50 MHz divider). Samples the divided clock in the 100 MHz CLK domain and emits one-cycle rise/fall strobes for fast-domain logic. Measures every high and low phase in CLK cycles and reports lock, phase-length errors and stalls, so game logic can gate on a verified slow clock.

## Interface
- DIV_HALF, 2: expected phase length in CLK cycles, for both the high and the low phase.
- LOCK_COUNT, 4: consecutive good full periods (2*LOCK_COUNT phases) required to lock.
- TIMEOUT, 16: run length that flags a stall; must be greater than DIV_HALF.
- CNT_W, 8: counter and report width; must hold TIMEOUT.
- CLK  in  1  100 MHz system clock.
- RST  in  1  reset, asynchronous, active-high.
- CLKIN  in  1  monitored divided clock, generated by a register clocked on CLK.
- CLR_ERR  in  1  one-cycle pulse that clears ERR and leaves FAULT.
- RISE  out  1  one-cycle strobe on a detected CLKIN rising edge.
- FALL  out  1  one-cycle strobe on a detected CLKIN falling edge.
- HIGH_CNT  out  CNT_W  length of the last completed high phase.
- LOW_CNT  out  CNT_W  length of the last completed low phase.
- LOCKED  out  1  CLKIN matches the expected period.
- ERR  out  1  sticky error flag.
- STALL  out  1  no CLKIN transition seen within TIMEOUT cycles.

## Operation
- **Reset:** every output is 0. Internal state: s0=0, s1=0, run_cnt=0, good_cnt=0, primed=0, state=SYNC.
- **Sampling:** CLKIN is already synchronous to CLK, so no synchroniser chain is needed.
  - Every edge: s0<=CLKIN, s1<=s0, primed<=1.
  - A transition is s0!=s1 with primed=1. The first sample after reset only initialises and never counts as a transition.
- **Strobes:** RISE<=transition&s0 and FALL<=transition&~s0, updated every cycle.
- **Run counter:**
  - On a transition: captured length = run_cnt, then run_cnt<=1.
  - Otherwise run_cnt increments, saturating at TIMEOUT.
  - The captured length goes to HIGH_CNT if the phase that just ended was high, else to LOW_CNT.
  - A phase is good when its length equals DIV_HALF.
- **States:**
  - SYNC: the first transition ends a partial phase. Discard it (HIGH_CNT/LOW_CNT not updated), set good_cnt=0 and go to CHECK.
  - CHECK: a good phase does good_cnt++. When good_cnt reaches 2*LOCK_COUNT, set LOCKED=1 and go to LOCKED. A bad phase sets good_cnt=0, stays in CHECK, and does not raise ERR.
  - LOCKED: a bad phase sets ERR=1, LOCKED=0 and goes to FAULT.
  - FAULT: phases are still measured and reported, but there is no relock. On CLR_ERR: ERR=0, go to SYNC.
- **Stall (all states):**
  - When run_cnt becomes TIMEOUT without a transition, set STALL=1.
  - If the state is LOCKED: ERR=1, LOCKED=0, go to SYNC. If CHECK: go to SYNC. If FAULT: stay in FAULT.
  - STALL clears on the next transition.
- **CLR_ERR outside FAULT:** clears ERR only.
- **Priority:** an ERR set condition in the same cycle as CLR_ERR wins, so ERR stays 1.
- **Reset mid-operation:** immediately returns everything to the reset state, independent of CLK.

## Timing
- Detection latency: CLKIN first sampled at its new value at CLK edge n. At edge n+1, RISE/FALL, HIGH_CNT/LOW_CNT, LOCKED, ERR and the state all update together.
- RISE and FALL are each exactly 1 cycle wide.
- Reporting: HIGH_CNT/LOW_CNT hold their value until the next completed phase of the same polarity.
- Period check: with a divide-by-4 CLKIN (2 high, 2 low), RISE fires every 4 cycles and both lengths equal 2.
- Lock latency after the first transition: 2*LOCK_COUNT*DIV_HALF cycles, which is 16 with the defaults.
- Stall latency: STALL rises exactly TIMEOUT-1 edges after the last transition edge, i.e. when run_cnt reaches TIMEOUT.

## Test plan
- **Lock:** reset, then CLKIN from a 2-high/2-low toggler with defaults → RISE every 4 cycles, HIGH_CNT=LOW_CNT=2, LOCKED=1 on the edge ending the 8th good phase after the discarded one, ERR=0.
- **Phase error:** while locked, stretch one high phase to 3 → on the FALL edge HIGH_CNT=3, ERR=1 and LOCKED=0. Later good phases do not relock. A CLR_ERR pulse makes ERR=0 on the next edge, and LOCKED returns after 8 more good phases.
- **Stall:** while locked, hold CLKIN low → STALL=1, ERR=1 and LOCKED=0 when run_cnt reaches 16. When toggling resumes, STALL=0 at the first transition and the block relocks without CLR_ERR, with ERR still 1.
- **CLKIN high at reset release:** → no RISE on the first cycles. The first FALL is reported but its phase is discarded (HIGH_CNT stays 0).
- **Async reset:** assert RST mid-lock between CLK edges → LOCKED, ERR, STALL, RISE, FALL, HIGH_CNT and LOW_CNT are all 0 immediately.
- **Simultaneous events:** CLR_ERR asserted in the same cycle a bad phase is detected in LOCKED → ERR=1 and the state is FAULT.

Source files
------------

// File: rtl/clkdiv_monitor.sv
// Watches a CLK-synchronous divided clock: edge strobes, phase-length reports,
// lock tracking against DIV_HALF, sticky phase errors and stall detection.
module clkdiv_monitor #(
  parameter int DIV_HALF   = 2,
  parameter int LOCK_COUNT = 4,
  parameter int TIMEOUT    = 16,
  parameter int CNT_W      = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CLKIN,
  input  logic             CLR_ERR,
  output logic             RISE,
  output logic             FALL,
  output logic [CNT_W-1:0] HIGH_CNT,
  output logic [CNT_W-1:0] LOW_CNT,
  output logic             LOCKED,
  output logic             ERR,
  output logic             STALL
);
  localparam int GOOD_TARGET = 2 * LOCK_COUNT;
  localparam int GW          = $clog2(GOOD_TARGET + 1);
  localparam logic [CNT_W-1:0] TO    = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] TO_M1 = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] DH    = CNT_W'(DIV_HALF);
  localparam logic [GW-1:0]    GT    = GW'(GOOD_TARGET);

  typedef enum logic [1:0] {ST_SYNC, ST_CHECK, ST_LOCKED, ST_FAULT} state_t;

  state_t           state_q, state_d;
  logic             s0_q, s0_d, s1_q, s1_d, primed_q, primed_d;
  logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
  logic [CNT_W-1:0] high_cnt_q, high_cnt_d, low_cnt_q, low_cnt_d;
  logic [GW-1:0]    good_cnt_q, good_cnt_d;
  logic             rise_q, rise_d, fall_q, fall_d;
  logic             locked_q, locked_d, err_q, err_d, stall_q, stall_d;
  logic             transition, phase_good, stall_evt, err_set;

  always_comb begin
    // The first sample after reset seeds both taps so it cannot look like an edge.
    s0_d       = CLKIN;
    s1_d       = primed_q ? s0_q : CLKIN;
    primed_d   = 1'b1;
    transition = primed_q && (s0_q != s1_q);
    phase_good = (run_cnt_q == DH);
    stall_evt  = !transition && (run_cnt_q == TO_M1);
    rise_d     = transition && s0_q;
    fall_d     = transition && !s0_q;

    if (transition)              run_cnt_d = CNT_W'(1);
    else if (run_cnt_q == TO)    run_cnt_d = TO;
    else                         run_cnt_d = run_cnt_q + CNT_W'(1);

    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    high_cnt_d = high_cnt_q;
    low_cnt_d  = low_cnt_q;
    locked_d   = locked_q;
    err_d      = err_q;
    stall_d    = stall_q;
    err_set    = 1'b0;

    if (transition) begin
      stall_d = 1'b0;
      // SYNC ends a partial phase, so its length is not reported.
      if (state_q != ST_SYNC) begin
        if (s0_q) low_cnt_d  = run_cnt_q;
        else      high_cnt_d = run_cnt_q;
      end
      unique case (state_q)
        ST_SYNC: begin
          good_cnt_d = '0;
          state_d    = ST_CHECK;
        end
        ST_CHECK: begin
          if (phase_good) begin
            good_cnt_d = good_cnt_q + GW'(1);
            if (good_cnt_d == GT) begin
              locked_d = 1'b1;
              state_d  = ST_LOCKED;
            end
          end else begin
            good_cnt_d = '0;
          end
        end
        ST_LOCKED: begin
          if (!phase_good) begin
            err_set  = 1'b1;
            locked_d = 1'b0;
            state_d  = ST_FAULT;
          end
        end
        default: ;
      endcase
    end else if (stall_evt) begin
      stall_d = 1'b1;
      if (state_q == ST_LOCKED) begin
        err_set  = 1'b1;
        locked_d = 1'b0;
        state_d  = ST_SYNC;
      end else if (state_q == ST_CHECK) begin
        state_d = ST_SYNC;
      end
    end

    if (CLR_ERR) begin
      err_d = 1'b0;
      if (state_q == ST_FAULT) state_d = ST_SYNC;
    end
    // A fresh error outranks a simultaneous clear.
    if (err_set) err_d = 1'b1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_SYNC;
      s0_q       <= 1'b0;
      s1_q       <= 1'b0;
      primed_q   <= 1'b0;
      run_cnt_q  <= '0;
      good_cnt_q <= '0;
      high_cnt_q <= '0;
      low_cnt_q  <= '0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      locked_q   <= 1'b0;
      err_q      <= 1'b0;
      stall_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      s0_q       <= s0_d;
      s1_q       <= s1_d;
      primed_q   <= primed_d;
      run_cnt_q  <= run_cnt_d;
      good_cnt_q <= good_cnt_d;
      high_cnt_q <= high_cnt_d;
      low_cnt_q  <= low_cnt_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      locked_q   <= locked_d;
      err_q      <= err_d;
      stall_q    <= stall_d;
    end
  end

  assign RISE     = rise_q;
  assign FALL     = fall_q;
  assign HIGH_CNT = high_cnt_q;
  assign LOW_CNT  = low_cnt_q;
  assign LOCKED   = locked_q;
  assign ERR      = err_q;
  assign STALL    = stall_q;
endmodule

// File: tb/tb_clkdiv_monitor.sv
// Bench for clkdiv_monitor: directed lock/error/stall/reset scenarios plus random phases.
module tb_clkdiv_monitor;
  localparam int DIV_HALF = 2, LOCK_COUNT = 4, TIMEOUT = 16, CNT_W = 8;
  localparam int M_SYNC = 0, M_CHECK = 1, M_LOCKED = 2, M_FAULT = 3;

  logic CLK = 1'b0;
  logic RST, CLKIN, CLR_ERR;
  logic RISE, FALL, LOCKED, ERR, STALL;
  logic [CNT_W-1:0] HIGH_CNT, LOW_CNT;

  clkdiv_monitor #(.DIV_HALF(DIV_HALF), .LOCK_COUNT(LOCK_COUNT), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST), .CLKIN(CLKIN), .CLR_ERR(CLR_ERR),
    .RISE(RISE), .FALL(FALL), .HIGH_CNT(HIGH_CNT), .LOW_CNT(LOW_CNT),
    .LOCKED(LOCKED), .ERR(ERR), .STALL(STALL)
  );

  always #5 CLK = ~CLK;

  int checks = 0, errors = 0;

  // Reference model: edge index since reset, sample history, edge index of last transition.
  int e, last_t, good, mode;
  bit p1, p2;
  bit m_rise, m_fall, m_locked, m_err, m_stall;
  int m_hcnt, m_lcnt;

  // Observations of the DUT used by the literal checks.
  int first_tr_e, lock_e, last_rise_e, rise_gap, last_tr_e, stall_gap, rise_cnt, fall_cnt;
  bit prev_stall;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d edge=%0d", name, act, exp, e);
    end
  endtask

  task automatic model_reset();
    e = 0; last_t = 1; good = 0; mode = M_SYNC; p1 = 0; p2 = 0;
    m_rise = 0; m_fall = 0; m_locked = 0; m_err = 0; m_stall = 0; m_hcnt = 0; m_lcnt = 0;
  endtask

  task automatic clear_track();
    first_tr_e = -1; lock_e = -1; last_rise_e = -1; rise_gap = -1;
    last_tr_e = -1; stall_gap = -1; rise_cnt = 0; fall_cnt = 0; prev_stall = 0;
  endtask

  task automatic model_edge(input bit v, input bit clr);
    bit trans, errset;
    int run, nmode;
    e++;
    trans = (e >= 3) && (p1 != p2);
    run = e - last_t;
    if (run > TIMEOUT) run = TIMEOUT;
    m_rise = trans && p1;
    m_fall = trans && !p1;
    errset = 0;
    nmode = mode;
    if (trans) begin
      last_t = e;
      m_stall = 0;
      if (mode != M_SYNC) begin
        if (p1) m_lcnt = run; else m_hcnt = run;
      end
      if (mode == M_SYNC) begin
        good = 0; nmode = M_CHECK;
      end else if (mode == M_CHECK) begin
        if (run == DIV_HALF) begin
          good++;
          if (good == 2 * LOCK_COUNT) begin m_locked = 1; nmode = M_LOCKED; end
        end else good = 0;
      end else if (mode == M_LOCKED && run != DIV_HALF) begin
        errset = 1; m_locked = 0; nmode = M_FAULT;
      end
    end else if (run == TIMEOUT - 1) begin
      m_stall = 1;
      if (mode == M_LOCKED) begin errset = 1; m_locked = 0; nmode = M_SYNC; end
      else if (mode == M_CHECK) nmode = M_SYNC;
    end
    if (clr) begin
      m_err = 0;
      if (mode == M_FAULT) nmode = M_SYNC;
    end
    if (errset) m_err = 1;
    mode = nmode;
    p2 = p1;
    p1 = v;
  endtask

  // Called just after a rising edge: drive inputs, advance one edge, compare.
  task automatic step(input bit v, input bit clr);
    CLKIN = v;
    CLR_ERR = clr;
    @(posedge CLK);
    model_edge(v, clr);
    #1;
    check("rise", RISE, m_rise);
    check("fall", FALL, m_fall);
    check("high_cnt", HIGH_CNT, m_hcnt);
    check("low_cnt", LOW_CNT, m_lcnt);
    check("locked", LOCKED, m_locked);
    check("err", ERR, m_err);
    check("stall", STALL, m_stall);
    if ((RISE || FALL) && first_tr_e < 0) first_tr_e = e;
    if (LOCKED && lock_e < 0) lock_e = e;
    if (RISE) begin
      if (last_rise_e > 0) rise_gap = e - last_rise_e;
      last_rise_e = e;
      rise_cnt++;
    end
    if (FALL) fall_cnt++;
    if (STALL && !prev_stall) stall_gap = e - last_tr_e;
    prev_stall = STALL;
    if (RISE || FALL) last_tr_e = e;
  endtask

  task automatic toggle(input int n);
    for (int i = 0; i < n; i++) begin
      step(1, 0); step(1, 0); step(0, 0); step(0, 0);
    end
  endtask

  // Called just after a rising edge; asserts RST between edges and checks outputs at once.
  task automatic do_reset(input bit v, input int dly);
    CLKIN = v;
    CLR_ERR = 0;
    #(dly);
    RST = 1;
    #1;
    check("rst_rise", RISE, 0);
    check("rst_fall", FALL, 0);
    check("rst_high", HIGH_CNT, 0);
    check("rst_low", LOW_CNT, 0);
    check("rst_locked", LOCKED, 0);
    check("rst_err", ERR, 0);
    check("rst_stall", STALL, 0);
    @(posedge CLK);
    #1;
    RST = 0;
    model_reset();
    clear_track();
  endtask

  initial begin
    int len, r;
    bit lvl;
    RST = 1; CLKIN = 0; CLR_ERR = 0;
    model_reset();
    clear_track();
    @(posedge CLK);
    #1;
    do_reset(0, 2);

    // Lock on a divide-by-4 clock.
    repeat (3) step(0, 0);
    toggle(12);
    check("lock_latency", lock_e - first_tr_e, 16);
    check("rise_period", rise_gap, 4);
    check("lock_high_len", HIGH_CNT, 2);
    check("lock_low_len", LOW_CNT, 2);
    check("lock_locked", LOCKED, 1);
    check("lock_err", ERR, 0);

    // Stretched high phase while locked, with CLR_ERR on the detecting edge.
    step(1, 0); step(1, 0); step(1, 0); step(0, 0); step(0, 1);
    check("bad_high_len", HIGH_CNT, 3);
    check("bad_err", ERR, 1);
    check("bad_locked", LOCKED, 0);
    toggle(10);
    check("no_relock", LOCKED, 0);
    check("fault_err_held", ERR, 1);
    step(1, 1);
    check("clr_err", ERR, 0);
    step(1, 0); step(0, 0); step(0, 0);
    toggle(6);
    check("relock_after_clr", LOCKED, 1);

    // Stall while locked.
    repeat (20) step(0, 0);
    check("stall_flag", STALL, 1);
    check("stall_err", ERR, 1);
    check("stall_locked", LOCKED, 0);
    check("stall_latency", stall_gap, 15);
    toggle(6);
    check("stall_cleared", STALL, 0);
    check("stall_relock", LOCKED, 1);
    check("stall_err_kept", ERR, 1);

    // CLKIN already high when reset releases.
    do_reset(1, 2);
    repeat (4) step(1, 0);
    check("no_rise_at_release", rise_cnt, 0);
    step(0, 0); step(0, 0);
    check("first_fall_seen", fall_cnt, 1);
    check("discarded_high", HIGH_CNT, 0);

    // Asynchronous reset mid-lock.
    toggle(8);
    check("pre_async_locked", LOCKED, 1);
    do_reset(0, 3);

    // Random phase lengths, occasional stalls and clear pulses.
    lvl = 0;
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 99);
      if (r < 65) len = 2;
      else if (r < 92) len = $urandom_range(1, 5);
      else len = $urandom_range(12, 20);
      lvl = ~lvl;
      for (int j = 0; j < len; j++) step(lvl, $urandom_range(0, 29) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
